or_reduce_packet: RTL and testbench

Sequential packet-level OR reducer that sits directly downstream of the bitwise OR gating stage. It consumes a valid/ready stream of WIDTH-bit words grouped into packets by `in_last`. It produces one registered word per packet: the bitwise OR of every beat in that packet, plus a beat count and an overflow flag. The accumulate path is built from 2:1 word muxes and constants, so the OR-by-mux construction is extended here into a clocked stage.

---
 rtl/or_reduce_pkg.sv | 11 +
 rtl/or_reduce_packet_mux_word.sv | 17 +
 rtl/or_reduce_packet.sv | 112 +++++++++++
 tb/tb_or_reduce_packet.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/or_reduce_pkg.sv
// Shared types and sizing helpers for the packet-level OR reducer.
package or_reduce_pkg;

  typedef enum logic {ACC, HOLD} or_red_state_t;

  // Width needed to represent beat counts 0..max_beats inclusive.
  function automatic int or_red_cw(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/or_reduce_packet_mux_word.sv
// Per-bit 2:1 word mux; each output bit picks d1 where its select bit is set.
module mux_word #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] sel_i,
  input  logic [WIDTH-1:0] d0_i,
  input  logic [WIDTH-1:0] d1_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      y_o[i] = sel_i[i] ? d1_i[i] : d0_i[i];
    end
  end

endmodule

// File: rtl/or_reduce_packet.sv
// Packet-level OR reducer: folds every beat of a packet into one registered
// word with a saturating beat count and an overflow flag.
module or_reduce_packet
  import or_reduce_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 in_data,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 out_data,
  output logic [or_red_cw(MAX_BEATS)-1:0]  out_beats,
  output logic                             out_overflow
);

  localparam int CW = or_red_cw(MAX_BEATS);

  or_red_state_t    state_q;
  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    cnt_q;
  logic             first_q;
  logic             ovf_q;
  logic [WIDTH-1:0] out_data_q;
  logic [CW-1:0]    out_beats_q;
  logic             out_ovf_q;

  logic [WIDTH-1:0] or_word;
  logic [WIDTH-1:0] acc_d;
  logic [CW-1:0]    cnt_d;
  logic             ovf_d;
  logic             cnt_at_max;
  logic             beat_acc;

  // OR built from muxes: a set input bit forces a one, otherwise keep acc.
  mux_word #(.WIDTH(WIDTH)) u_or_mask (
    .sel_i (in_data),
    .d0_i  (acc_q),
    .d1_i  ({WIDTH{1'b1}}),
    .y_o   (or_word)
  );

  mux_word #(.WIDTH(WIDTH)) u_first_sel (
    .sel_i ({WIDTH{first_q}}),
    .d0_i  (or_word),
    .d1_i  (in_data),
    .y_o   (acc_d)
  );

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == HOLD);
  assign beat_acc  = in_valid && in_ready;

  assign cnt_at_max = (cnt_q == CW'(MAX_BEATS));

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (first_q) begin
      cnt_d = CW'(1);
      ovf_d = 1'b0;
    end else begin
      cnt_d = cnt_at_max ? cnt_q : cnt_q + CW'(1);
      ovf_d = ovf_q | cnt_at_max;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      first_q     <= 1'b1;
      ovf_q       <= 1'b0;
      out_data_q  <= '0;
      out_beats_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (beat_acc) begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            first_q <= in_last;
            if (in_last) begin
              out_data_q  <= acc_d;
              out_beats_q <= cnt_d;
              out_ovf_q   <= ovf_d;
              state_q     <= HOLD;
            end
          end
        end
        HOLD: begin
          // No bypass: the handshake cycle itself is the per-packet bubble.
          if (out_ready) state_q <= ACC;
        end
        default: state_q <= ACC;
      endcase
    end
  end

  assign out_data     = out_data_q;
  assign out_beats    = out_beats_q;
  assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_or_reduce_packet.sv
// Randomized self-checking bench for or_reduce_packet (WIDTH=8, MAX_BEATS=4).
module tb_or_reduce_packet;

  localparam int WIDTH = 8;
  localparam int MAXB  = 4;
  localparam int CW    = $clog2(MAXB + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    out_beats;
  logic             out_overflow;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  or_reduce_packet #(.WIDTH(WIDTH), .MAX_BEATS(MAXB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_beats    (out_beats),
    .out_overflow (out_overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until the DUT takes it (bounded).
  task automatic send_beat(input logic [WIDTH-1:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
    end
    step();
    in_valid = 1'b0;
    in_data  = $urandom;
    in_last  = $urandom_range(0, 1);
  endtask

  // Wait for a result, optionally stall it, compare, then handshake.
  task automatic collect(input string name, input logic [WIDTH-1:0] ed,
                         input int beats, input logic eo, input int hold);
    int n = 0;
    out_ready = 1'b0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_valid got=%0b required=1", name, out_valid);
    end
    repeat (hold) step();
    checks++;
    if (out_data !== ed) begin
      failures++;
      $display("FAIL %s_data got=%h required=%h", name, out_data, ed);
    end
    checks++;
    if (out_beats !== CW'(beats)) begin
      failures++;
      $display("FAIL %s_beats got=%0d required=%0d", name, out_beats, beats);
    end
    checks++;
    if (out_overflow !== eo) begin
      failures++;
      $display("FAIL %s_ovf got=%0b required=%0b", name, out_overflow, eo);
    end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs got=%0b%0b required=10", in_ready, out_valid);
    end
    checks++;
    if (out_data !== '0 || out_beats !== '0 || out_overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_out got=%h/%0d/%0b required=00/0/0",
               out_data, out_beats, out_overflow);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_packet();
    send_beat(8'h01, 1'b0);
    send_beat(8'h02, 1'b0);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step();
    send_beat(8'h40, 1'b1);
    collect("rst_mid", 8'h40, 1, 1'b0, 0);
  endtask

  task automatic test_multi_beat();
    out_ready = 1'b1;
    send_beat(8'h01, 1'b0);
    send_beat(8'h04, 1'b0);
    send_beat(8'h80, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL multi_latency valid/ready got=%0b/%0b required=1/0",
               out_valid, in_ready);
    end
    checks++;
    if (out_data !== 8'h85 || out_beats !== CW'(3) || out_overflow !== 1'b0) begin
      failures++;
      $display("FAIL multi_result got=%h/%0d/%0b required=85/3/0",
               out_data, out_beats, out_overflow);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL multi_release valid/ready got=%0b/%0b required=0/1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_single_beat();
    send_beat(8'h5A, 1'b1);
    collect("single", 8'h5A, 1, 1'b0, 0);
    send_beat(8'h00, 1'b1);
    collect("after_single", 8'h00, 1, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    logic ok_ready;
    logic ok_stable;
    out_ready = 1'b0;
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b1);
    in_valid  = 1'b1;
    in_data   = 8'h99;
    in_last   = 1'b1;
    ok_ready  = 1'b1;
    ok_stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (in_ready !== 1'b0) ok_ready = 1'b0;
      if (out_valid !== 1'b1 || out_data !== 8'h33 || out_beats !== CW'(2) ||
          out_overflow !== 1'b0) ok_stable = 1'b0;
      step();
    end
    checks++;
    if (!ok_ready) begin
      failures++;
      $display("FAIL bp_ready got=ready_seen required=0_for_5_cycles");
    end
    checks++;
    if (!ok_stable) begin
      failures++;
      $display("FAIL bp_stable got=%h/%0d required=33/2", out_data, out_beats);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_handshake valid/ready got=%0b/%0b required=0/1",
               out_valid, in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h99 || out_beats !== CW'(1)) begin
      failures++;
      $display("FAIL bp_next got=%0b/%h/%0d required=1/99/1",
               out_valid, out_data, out_beats);
    end
    collect("bp_next", 8'h99, 1, 1'b0, 0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) send_beat(8'h10, (i == 5));
    collect("ovf", 8'h10, 4, 1'b1, 0);
    send_beat(8'h01, 1'b0);
    send_beat(8'h02, 1'b1);
    collect("ovf_after", 8'h03, 2, 1'b0, 0);
    for (int i = 0; i < 4; i++) send_beat(8'h08, (i == 3));
    collect("exact_max", 8'h08, 4, 1'b0, 0);
  endtask

  task automatic test_idle_gaps();
    repeat ($urandom_range(1, 4)) step();
    send_beat(8'h03, 1'b0);
    repeat ($urandom_range(1, 5)) step();
    send_beat(8'h30, 1'b1);
    collect("gaps", 8'h33, 2, 1'b0, 0);
  endtask

  // Reference: OR of all beats, count clipped at MAXB, overflow if longer.
  task automatic test_random();
    for (int p = 0; p < 25; p++) begin
      int len;
      logic [WIDTH-1:0] beats_q[$];
      logic [WIDTH-1:0] exp_or;
      len = $urandom_range(1, 7);
      beats_q.delete();
      for (int b = 0; b < len; b++) beats_q.push_back(WIDTH'($urandom));
      exp_or = '0;
      foreach (beats_q[b]) exp_or = exp_or | beats_q[b];
      foreach (beats_q[b]) begin
        repeat ($urandom_range(0, 2)) step();
        send_beat(beats_q[b], (b == len - 1));
      end
      collect("rand", exp_or, (len > MAXB) ? MAXB : len, (len > MAXB),
              $urandom_range(0, 3));
    end
  endtask

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_reset_mid_packet();
    test_multi_beat();
    test_single_beat();
    test_backpressure();
    test_overflow();
    test_idle_gaps();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
